// File: rtl/etch_cursor_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : etch_cursor_sequencer
// Brief    : Rotary events -> clamped drawing cursor; sequences framebuffer pixel
//            writes (valid/ready) with round-robin X/Y service and screen clear.
// Revision : 1.0
// ============================================================================
module etch_cursor_sequencer #(
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int PEND_LIM = 7
) (
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    input  logic          x_cw,
    input  logic          x_ccw,
    input  logic          y_cw,
    input  logic          y_ccw,
    input  logic          clear_req,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_colour,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic [7:0]    seg_value,
    output logic          busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WRITE = 2'd1;
    localparam logic [1:0] c_CLEAR = 2'd2;

    localparam logic [XW-1:0]     c_X_MAX  = XW'(X_MAX);
    localparam logic [YW-1:0]     c_Y_MAX  = YW'(Y_MAX);
    localparam logic [XW-1:0]     c_X_HOME = XW'(X_MAX >> 1);
    localparam logic [YW-1:0]     c_Y_HOME = YW'(Y_MAX >> 1);
    localparam logic signed [4:0] c_PHI    = 5'(PEND_LIM);
    localparam logic signed [4:0] c_PLO    = -5'(PEND_LIM);

    logic [1:0]        r_state;
    logic [XW-1:0]     r_cur_x, r_pix_x, r_scan_x;
    logic [YW-1:0]     r_cur_y, r_pix_y, r_scan_y;
    logic signed [3:0] r_pend_x, r_pend_y;
    logic              r_clr_pend, r_rr, r_pix_valid, r_pix_colour, r_scan_done;
    logic [7:0]        r_seg;

    logic              w_serve_x, w_serve_y, w_x_up, w_y_up, w_x_block, w_y_block;
    logic [XW-1:0]     w_x_next;
    logic [YW-1:0]     w_y_next;
    logic signed [3:0] w_pend_x_next, w_pend_y_next;

    // Net of rotary event and FSM service, then saturate to +/-PEND_LIM.
    function automatic logic signed [3:0] pend_update(input logic signed [3:0] p,
                                                      input logic up, input logic dn,
                                                      input logic serve);
        logic signed [4:0] s;
        s = {p[3], p};
        if (up)    s = s + 5'sd1;
        if (dn)    s = s - 5'sd1;
        if (serve) s = p[3] ? s + 5'sd1 : s - 5'sd1;
        if (s > c_PHI) s = c_PHI;
        if (s < c_PLO) s = c_PLO;
        return s[3:0];
    endfunction

    always_comb begin
        w_serve_x     = (r_state == c_IDLE) && !r_clr_pend && (r_pend_x != 4'sd0)
                        && (!r_rr || (r_pend_y == 4'sd0));
        w_serve_y     = (r_state == c_IDLE) && !r_clr_pend && (r_pend_y != 4'sd0)
                        && !w_serve_x;
        w_x_up        = !r_pend_x[3];
        w_y_up        = !r_pend_y[3];
        w_x_block     = w_x_up ? (r_cur_x == c_X_MAX) : (r_cur_x == '0);
        w_y_block     = w_y_up ? (r_cur_y == c_Y_MAX) : (r_cur_y == '0);
        w_x_next      = w_x_up ? r_cur_x + XW'(1) : r_cur_x - XW'(1);
        w_y_next      = w_y_up ? r_cur_y + YW'(1) : r_cur_y - YW'(1);
        w_pend_x_next = pend_update(r_pend_x, x_cw, x_ccw, w_serve_x);
        w_pend_y_next = pend_update(r_pend_y, y_cw, y_ccw, w_serve_y);
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state      <= c_IDLE;
            r_cur_x      <= c_X_HOME;
            r_cur_y      <= c_Y_HOME;
            r_pend_x     <= 4'sd0;
            r_pend_y     <= 4'sd0;
            r_clr_pend   <= 1'b0;
            r_rr         <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_pix_colour <= 1'b0;
            r_seg        <= 8'd0;
            r_scan_x     <= '0;
            r_scan_y     <= '0;
            r_scan_done  <= 1'b0;
        end else begin
            r_pend_x <= w_pend_x_next;
            r_pend_y <= w_pend_y_next;
            case (r_state)
                c_IDLE: begin
                    if (r_clr_pend) begin
                        r_clr_pend  <= 1'b0;
                        r_scan_x    <= '0;
                        r_scan_y    <= '0;
                        r_scan_done <= 1'b0;
                        r_state     <= c_CLEAR;
                    end else if (w_serve_x) begin
                        r_rr <= 1'b1;
                        if (!w_x_block) begin
                            r_cur_x      <= w_x_next;
                            r_pix_x      <= w_x_next;
                            r_pix_y      <= r_cur_y;
                            r_pix_colour <= 1'b1;
                            r_pix_valid  <= 1'b1;
                            r_state      <= c_WRITE;
                        end
                    end else if (w_serve_y) begin
                        r_rr <= 1'b0;
                        if (!w_y_block) begin
                            r_cur_y      <= w_y_next;
                            r_pix_x      <= r_cur_x;
                            r_pix_y      <= w_y_next;
                            r_pix_colour <= 1'b1;
                            r_pix_valid  <= 1'b1;
                            r_state      <= c_WRITE;
                        end
                    end
                end
                c_WRITE: begin
                    if (pix_ready) begin
                        r_pix_valid <= 1'b0;
                        r_seg       <= r_seg + 8'd1;
                        r_state     <= c_IDLE;
                    end
                end
                c_CLEAR: begin
                    if (r_pix_valid) begin
                        if (pix_ready) begin
                            r_pix_valid <= 1'b0;
                            if (r_scan_x == c_X_MAX) begin
                                r_scan_x <= '0;
                                if (r_scan_y == c_Y_MAX) r_scan_done <= 1'b1;
                                else                     r_scan_y    <= r_scan_y + YW'(1);
                            end else begin
                                r_scan_x <= r_scan_x + XW'(1);
                            end
                        end
                    end else if (r_scan_done) begin
                        // Redraw the cursor dot the clear just erased.
                        r_pix_x      <= r_cur_x;
                        r_pix_y      <= r_cur_y;
                        r_pix_colour <= 1'b1;
                        r_pix_valid  <= 1'b1;
                        r_state      <= c_WRITE;
                    end else begin
                        r_pix_x      <= r_scan_x;
                        r_pix_y      <= r_scan_y;
                        r_pix_colour <= 1'b0;
                        r_pix_valid  <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
            // Placed last so a request coincident with CLEAR entry is not lost.
            if (clear_req) r_clr_pend <= 1'b1;
        end
    end

    assign pix_valid  = r_pix_valid;
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign pix_colour = r_pix_colour;
    assign cur_x      = r_cur_x;
    assign cur_y      = r_cur_y;
    assign seg_value  = r_seg;
    assign busy       = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_etch_cursor_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_etch_cursor_sequencer
// Brief    : Scoreboard bench for etch_cursor_sequencer on an 8x4 screen.
// Revision : 1.0
// ============================================================================
module tb_etch_cursor_sequencer;

    typedef struct packed {
        logic [2:0] x;
        logic [1:0] y;
        logic       c;
    } pix_t;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic       x_cw = 1'b0, x_ccw = 1'b0, y_cw = 1'b0, y_ccw = 1'b0;
    logic       clear_req = 1'b0;
    logic       pix_ready = 1'b1;
    logic       pix_valid, pix_colour, busy;
    logic [2:0] pix_x, cur_x;
    logic [1:0] pix_y, cur_y;
    logic [7:0] seg_value;

    pix_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    etch_cursor_sequencer #(
        .X_MAX(7), .Y_MAX(3), .XW(3), .YW(2), .PEND_LIM(7)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .x_cw(x_cw), .x_ccw(x_ccw), .y_cw(y_cw), .y_ccw(y_ccw),
        .clear_req(clear_req),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
        .cur_x(cur_x), .cur_y(cur_y), .seg_value(seg_value), .busy(busy)
    );

    always #5 clk_clk = ~clk_clk;

    // Monitor: every handshake that the next rising edge will complete.
    initial begin
        pix_t got, e;
        forever begin
            @(negedge clk_clk);
            if (reset_reset_n && pix_valid && pix_ready) begin
                got = '{x: pix_x, y: pix_y, c: pix_colour};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got (%0d,%0d,c=%0d), none expected",
                             got.x, got.y, got.c);
                end else begin
                    e = exp_q.pop_front();
                    if (got != e) begin
                        errors++;
                        $display("FAIL pixel_write: got (%0d,%0d,c=%0d), expected (%0d,%0d,c=%0d)",
                                 got.x, got.y, got.c, e.x, e.y, e.c);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int x, input int y, input int c);
        exp_q.push_back('{x: 3'(x), y: 2'(y), c: 1'(c)});
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        tick();
        tick();
        reset_reset_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic wait_quiet(input string name);
        int quiet = 0;
        int n = 0;
        while (quiet < 8 && n < 2000) begin
            tick();
            n++;
            if (!busy && !pix_valid) quiet++;
            else                     quiet = 0;
        end
        chk(name, quiet, 8);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!pix_valid && n < 100) begin
            tick();
            n++;
        end
        chk(name, int'(pix_valid), 1);
    endtask

    initial begin
        logic [2:0] hx;
        logic [1:0] hy;
        logic       hc;
        tick();
        do_reset();

        // Reset state
        chk("rst_valid", int'(pix_valid), 0);
        chk("rst_cur_x", int'(cur_x), 3);
        chk("rst_cur_y", int'(cur_y), 1);
        chk("rst_seg", int'(seg_value), 0);
        chk("rst_busy", int'(busy), 0);

        // Single move: valid rises at the second edge after the pulse
        push(4, 1, 1);
        x_cw = 1'b1;
        tick();
        x_cw = 1'b0;
        chk("t1_valid_e1", int'(pix_valid), 0);
        tick();
        chk("t1_valid_e2", int'(pix_valid), 1);
        chk("t1_pix_x", int'(pix_x), 4);
        chk("t1_cur_x", int'(cur_x), 4);
        tick();
        chk("t1_seg", int'(seg_value), 1);

        // Backpressure: pixel fields hold while ready is low
        pix_ready = 1'b0;
        push(3, 1, 1);
        x_ccw = 1'b1;
        tick();
        x_ccw = 1'b0;
        wait_valid("t2_valid_timeout");
        hx = pix_x; hy = pix_y; hc = pix_colour;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_valid", int'(pix_valid), 1);
            chk("t2_hold_xyc", int'({pix_x, pix_y, pix_colour}), int'({hx, hy, hc}));
        end
        pix_ready = 1'b1;
        wait_quiet("t2_quiet_timeout");
        chk("t2_seg", int'(seg_value), 2);
        chk("t2_cur_x", int'(cur_x), 3);

        // Saturation and clamp at the left edge
        pix_ready = 1'b0;
        push(2, 1, 1); push(1, 1, 1); push(0, 1, 1);
        x_ccw = 1'b1;
        repeat (10) tick();
        x_ccw = 1'b0;
        pix_ready = 1'b1;
        wait_quiet("t3_quiet_timeout");
        chk("t3_cur_x", int'(cur_x), 0);
        chk("t3_cur_y", int'(cur_y), 1);
        chk("t3_seg", int'(seg_value), 5);

        // Round-robin from a fresh reset (X favoured first)
        do_reset();
        chk("t4_rst_cur_x", int'(cur_x), 3);
        push(4, 1, 1); push(4, 2, 1); push(5, 2, 1); push(5, 3, 1);
        x_cw = 1'b1; y_cw = 1'b1;
        tick();
        tick();
        x_cw = 1'b0; y_cw = 1'b0;
        wait_quiet("t4_quiet_timeout");
        chk("t4_cur_x", int'(cur_x), 5);
        chk("t4_cur_y", int'(cur_y), 3);
        chk("t4_seg", int'(seg_value), 4);

        // cw and ccw together cancel
        x_cw = 1'b1; x_ccw = 1'b1;
        tick();
        x_cw = 1'b0; x_ccw = 1'b0;
        repeat (6) tick();
        chk("t5_busy", int'(busy), 0);
        chk("t5_cur_x", int'(cur_x), 5);
        chk("t5_seg", int'(seg_value), 4);

        // Full clear, cursor redraw, then the x_cw event queued during the clear
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                push(x, y, 0);
        push(5, 3, 1);
        push(6, 3, 1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (5) tick();
        x_cw = 1'b1;
        tick();
        x_cw = 1'b0;
        wait_quiet("t6_quiet_timeout");
        chk("t6_cur_x", int'(cur_x), 6);
        chk("t6_seg", int'(seg_value), 6);

        // Right and bottom edge clamps
        push(7, 3, 1);
        x_cw = 1'b1; tick(); x_cw = 1'b0;
        wait_quiet("t6b_quiet_timeout");
        x_cw = 1'b1; tick(); x_cw = 1'b0;
        y_cw = 1'b1; tick(); y_cw = 1'b0;
        wait_quiet("t6c_quiet_timeout");
        chk("t6_edge_cur_x", int'(cur_x), 7);
        chk("t6_edge_cur_y", int'(cur_y), 3);
        chk("t6_edge_seg", int'(seg_value), 7);
        chk("queue_drained", exp_q.size(), 0);

        // Reset mid-clear with a write outstanding
        pix_ready = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_valid("t7_valid_timeout");
        chk("t7_clear_colour", int'(pix_colour), 0);
        reset_reset_n = 1'b0;
        tick();
        chk("t7_valid", int'(pix_valid), 0);
        chk("t7_busy", int'(busy), 0);
        chk("t7_cur_x", int'(cur_x), 3);
        chk("t7_cur_y", int'(cur_y), 1);
        chk("t7_seg", int'(seg_value), 0);
        reset_reset_n = 1'b1;
        exp_q.delete();
        pix_ready = 1'b1;
        repeat (10) tick();
        chk("t7_no_resume", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
